intersection_phase_arbiter: RTL and testbench
=============================================

Name: intersection_phase_arbiter

Overview:
- Four-approach green-phase scheduler for a single intersection.
- Shares the right-of-way between vehicle-presence requesters using round-robin with minimum/maximum green, yellow and all-red clearance timing.
- Emergency preemption forces green to a selected approach.
- Drives the per-approach 3-bit lamp codes used across the traffic blocks: 001 green, 010 yellow, 100 red.

Parameters:
- MIN_GREEN, 5, minimum green duration in ticks before a voluntary handover.
- MAX_GREEN, 15, green duration in ticks after which a contested green is forced to end.
- YELLOW_T, 3, yellow duration in ticks.
- ALLRED_T, 2, all-red clearance duration in ticks.
- TW, 5, timer width in bits. Must hold MAX_GREEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- tick  in  1  single-cycle timebase enable; all durations count tick pulses.
- req  in  4  vehicle presence per approach, level, sampled every cycle.
- emg_req  in  1  emergency preemption request, level.
- emg_dir  in  2  approach to receive the emergency green.
- lamps  out  12  lamp code per approach; approach i is bits [3i+2:3i].
- active  out  2  approach currently owning green or yellow; last owner during all-red.
- emg_ack  out  1  high while the emergency green is held.

Behaviour:
- Reset (rst=0, async):
  - state ALL_RED, timer 0, last-served pointer 3 (next search starts at approach 0).
  - active=0, emg_ack=0, lamps all 100, emergency latch cleared.
  - A reset mid-phase forces all-red immediately.
- Outputs are a combinational decode of registered state and active; there is no extra latency.
- Timer:
  - Cleared on every state entry.
  - Increments on cycles with tick=1 and saturates at MAX_GREEN.
  - "After N ticks" means the transition occurs at the clock edge where tick=1 and timer==N-1.
- Emergency latch:
  - When emg_req=1 and no latch is held, capture emg_dir into emg_q.
  - The latch clears if emg_req falls before EMG_HOLD is reached, or on exit from EMG_HOLD.
  - emg_dir changes while latched are ignored.
- ALL_RED:
  - All lamps 100.
  - After ALLRED_T ticks:
    - If the latch is held, go to EMG_HOLD with active=emg_q.
    - Else if any req is set, grant the first set req searching from (pointer+1) mod 4. Go to GREEN with active set to the granted approach and pointer set to it.
    - Else remain in ALL_RED (idle, timer saturated); grant on the first tick cycle any req appears.
- GREEN:
  - lamps[active]=001, others 100. "others_req" means any req other than req[active].
  - Latched emergency with emg_q==active: go to EMG_HOLD on the next edge, timer cleared; no tick needed.
  - Latched emergency with emg_q!=active: go to YELLOW on the next edge, ignoring MIN_GREEN.
  - Otherwise go to YELLOW on a tick edge when timer>=MIN_GREEN-1, others_req=1, and either req[active]=0 or timer>=MAX_GREEN-1.
  - With no competing request, green holds indefinitely.
- YELLOW:
  - lamps[active]=010, others 100.
  - Always completes YELLOW_T ticks; an emergency never shortens it.
  - Then go to ALL_RED.
- EMG_HOLD:
  - lamps[emg_q]=001, others 100, emg_ack=1, pointer=emg_q.
  - When emg_req=0, go to YELLOW on that approach and clear the latch; normal rotation resumes after emg_q.
- Simultaneous events:
  - emg_req rising on the same edge a normal grant is made in ALL_RED: the emergency wins.
  - req changes on a transition edge: the value sampled at that edge is used.
- Invariant: at most one approach is non-red in any cycle.
- Unused state encodings recover to ALL_RED.

Test Plan:
- tick=1, req=4'b0100 from reset release -> lamps all 100 for 2 cycles, then lamps[8:6]=001 held for 40 cycles, emg_ack=0.
- Green on approach 2, req becomes 4'b1100 at green cycle 1 (req[2] stays 1) -> green exactly 15 cycles, yellow 3, all-red 2, then lamps[11:9]=001, active=3.
- req=4'b1111 held -> grant order 0,1,2,3,0; each green 15 cycles; never two non-red approaches.
- Green on 0 at cycle 2, emg_req=1 emg_dir=2 -> yellow next cycle on 0 for 3 cycles, all-red 2, lamps[8:6]=001 with emg_ack=1 until emg_req=0, then yellow on 2, all-red, next grant searches from 3.
- emg_req pulsed 1 cycle during yellow, then low -> latch cleared, no EMG_HOLD, normal round-robin continues.
- rst=0 asserted asynchronously mid-yellow on approach 1 -> lamps all 100 immediately and active=0; after release, 2-cycle all-red, then grant starting from approach 0.

Source files
------------

// File: rtl/intersection_phase_arbiter_if.sv
// Request/lamp bundle between the intersection controller and its surroundings.
// The master drives the timebase and requests; the slave (the arbiter) drives the lamps.
interface intersection_phase_arbiter_if;
    logic        tick;
    logic [3:0]  req;
    logic        emg_req;
    logic [1:0]  emg_dir;
    logic [11:0] lamps;
    logic [1:0]  active;
    logic        emg_ack;

    modport master (
        output tick, req, emg_req, emg_dir,
        input  lamps, active, emg_ack
    );

    modport slave (
        input  tick, req, emg_req, emg_dir,
        output lamps, active, emg_ack
    );
endinterface

// File: rtl/intersection_phase_arbiter.sv
// Four-approach green-phase scheduler: round-robin with min/max green, yellow and
// all-red clearance, plus emergency preemption to a selected approach.
module intersection_phase_arbiter #(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int TW        = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    intersection_phase_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ALL_RED  = 2'd0,
        GREEN    = 2'd1,
        YELLOW   = 2'd2,
        EMG_HOLD = 2'd3
    } state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    localparam logic [TW-1:0] TIMER_SAT   = TW'(MAX_GREEN);
    localparam logic [TW-1:0] MIN_LAST    = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST    = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    active;
    logic [1:0]    pointer;
    logic [1:0]    emg_q;
    logic          emg_held;

    logic [1:0]    emg_target;
    logic [1:0]    grant;
    logic          any_req;
    logic          others_req;
    logic          allred_done;
    logic          yellow_done;
    logic          green_may_end;
    logic [11:0]   lamps;

    // Nearest requester after ptr wins; ptr itself is considered last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // NOTE: every signal driven here gets a value before any branch so no latch is inferred.
    always_comb begin
        emg_target    = emg_held ? emg_q : bus.emg_dir;
        any_req       = |bus.req;
        grant         = rr_pick(bus.req, pointer);
        others_req    = |(bus.req & ~(4'b0001 << active));
        allred_done   = bus.tick && (timer >= ALLRED_LAST);
        yellow_done   = bus.tick && (timer >= YELLOW_LAST);
        green_may_end = bus.tick && (timer >= MIN_LAST) && others_req &&
                        (!bus.req[active] || (timer >= MAX_LAST));
    end

    // NOTE: state registers use non-blocking assignments; later assignments in the
    // same edge (e.g. timer clear on a state change) override the default increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ALL_RED;
            timer    <= '0;
            active   <= 2'd0;
            pointer  <= 2'd3;
            emg_q    <= 2'd0;
            emg_held <= 1'b0;
        end else begin
            // A dropped request always clears the latch; exit from EMG_HOLD needs emg_req=0 too.
            if (!bus.emg_req) begin
                emg_held <= 1'b0;
            end else if (!emg_held) begin
                emg_held <= 1'b1;
                emg_q    <= bus.emg_dir;
            end

            if (bus.tick && (timer != TIMER_SAT)) begin
                timer <= timer + TW'(1);
            end

            case (state)
                ALL_RED: begin
                    if (allred_done) begin
                        if (bus.emg_req) begin
                            state   <= EMG_HOLD;
                            active  <= emg_target;
                            pointer <= emg_target;
                            timer   <= '0;
                        end else if (any_req) begin
                            state   <= GREEN;
                            active  <= grant;
                            pointer <= grant;
                            timer   <= '0;
                        end
                    end
                end

                GREEN: begin
                    if (bus.emg_req) begin
                        state <= (emg_target == active) ? EMG_HOLD : YELLOW;
                        timer <= '0;
                    end else if (green_may_end) begin
                        state <= YELLOW;
                        timer <= '0;
                    end
                end

                YELLOW: begin
                    if (yellow_done) begin
                        state <= ALL_RED;
                        timer <= '0;
                    end
                end

                EMG_HOLD: begin
                    if (!bus.emg_req) begin
                        state <= YELLOW;
                        timer <= '0;
                    end
                end

                default: begin
                    state <= ALL_RED;
                    timer <= '0;
                end
            endcase
        end
    end

    always_comb begin
        lamps = {4{LAMP_RED}};
        case (state)
            GREEN, EMG_HOLD: lamps[3*int'(active) +: 3] = LAMP_GREEN;
            YELLOW:          lamps[3*int'(active) +: 3] = LAMP_YELLOW;
            default:         lamps = {4{LAMP_RED}};
        endcase
    end

    assign bus.lamps   = lamps;
    assign bus.active  = active;
    assign bus.emg_ack = (state == EMG_HOLD);

    logic [3:0] live;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            live[i] = (lamps[3*i +: 3] != LAMP_RED);
        end
    end

    a_single_live: assert property (@(posedge clk) disable iff (!rst) $onehot0(live));
    a_ack_owner:   assert property (@(posedge clk) disable iff (!rst)
                                    (state == EMG_HOLD) |-> (active == emg_q));

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Randomized bench for intersection_phase_arbiter against a phase-level reference model.
module tb_intersection_phase_arbiter;

    localparam int MIN_GREEN = 5;
    localparam int MAX_GREEN = 15;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    intersection_phase_arbiter_if bus();

    intersection_phase_arbiter #(
        .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .TW(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: phase name, ticks elapsed in phase (unbounded), owner, last served.
    string m_phase;
    int    m_ticks;
    int    m_owner;
    int    m_last;
    bit    m_held;
    int    m_emg;

    task automatic model_reset();
        m_phase = "red";
        m_ticks = 0;
        m_owner = 0;
        m_last  = 3;
        m_held  = 1'b0;
        m_emg   = 0;
    endtask

    function automatic int first_req(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input bit t, input logic [3:0] r, input bit e, input int ed);
        string nxt;
        int    target;
        int    reached;
        int    g;
        bit    contested;
        nxt     = m_phase;
        target  = m_held ? m_emg : ed;
        reached = m_ticks + (t ? 1 : 0);
        if (m_phase == "red") begin
            if (t && reached >= ALLRED_T) begin
                if (e) begin
                    nxt = "emg"; m_owner = target; m_last = target;
                end else begin
                    g = first_req(r, m_last);
                    if (g >= 0) begin
                        nxt = "green"; m_owner = g; m_last = g;
                    end
                end
            end
        end else if (m_phase == "green") begin
            contested = (r & ~(4'b0001 << m_owner)) != 4'b0000;
            if (e) begin
                nxt = (target == m_owner) ? "emg" : "yellow";
            end else if (t && reached >= MIN_GREEN && contested &&
                         (!r[m_owner] || reached >= MAX_GREEN)) begin
                nxt = "yellow";
            end
        end else if (m_phase == "yellow") begin
            if (t && reached >= YELLOW_T) nxt = "red";
        end else begin
            if (!e) nxt = "yellow";
        end
        if (!e) m_held = 1'b0;
        else if (!m_held) begin
            m_held = 1'b1;
            m_emg  = ed;
        end
        m_ticks = (nxt != m_phase) ? 0 : reached;
        m_phase = nxt;
    endtask

    function automatic logic [14:0] model_out();
        logic [11:0] l;
        l = 12'h924;
        if (m_phase == "green" || m_phase == "emg") l[3*m_owner +: 3] = 3'b001;
        else if (m_phase == "yellow")               l[3*m_owner +: 3] = 3'b010;
        return {l, 2'(m_owner), m_phase == "emg"};
    endfunction

    // Compare at the negedge, then drive the next inputs and advance the model.
    task automatic run_cycle(input bit t, input logic [3:0] r, input bit e, input logic [1:0] ed);
        int live;
        @(negedge clk);
        check("outputs", 32'({bus.lamps, bus.active, bus.emg_ack}), 32'(model_out()));
        live = 0;
        for (int i = 0; i < 4; i++) if (bus.lamps[3*i +: 3] != 3'b100) live++;
        check("one_live", 32'(live <= 1), 32'd1);
        bus.tick    = t;
        bus.req     = r;
        bus.emg_req = e;
        bus.emg_dir = ed;
        model_step(t, r, e, int'(ed));
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_lamps",  32'(bus.lamps),   32'h924);
        check("rst_active", 32'(bus.active),  32'd0);
        check("rst_ack",    32'(bus.emg_ack), 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        int          tick_mode;
        int          emg_left;
        logic [3:0]  req_v;
        logic [1:0]  dir_v;
        bit          t;
        bus.tick = 1'b0; bus.req = 4'b0; bus.emg_req = 1'b0; bus.emg_dir = 2'd0;
        model_reset();
        #7 rst = 1'b1;

        // Lone requester on approach 2: two all-red cycles, then green held.
        for (int i = 0; i < 42; i++) begin
            run_cycle(1'b1, 4'b0100, 1'b0, 2'd0);
            if (i < 2)             check("plan1_red",   32'(bus.lamps), 32'h924);
            if (i == 2 || i == 41) check("plan1_green", 32'(bus.lamps), 32'h864);
            if (i == 41)           check("plan1_ack",   32'(bus.emg_ack), 32'd0);
        end
        // Contested green, then full rotation.
        for (int i = 0; i < 30; i++) run_cycle(1'b1, 4'b1100, 1'b0, 2'd0);
        for (int i = 0; i < 100; i++) run_cycle(1'b1, 4'b1111, 1'b0, 2'd0);
        // Emergency toward approach 2, then released.
        for (int i = 0; i < 30; i++) run_cycle(1'b1, 4'b1111, 1'b1, (i < 3) ? 2'd2 : 2'(i));
        for (int i = 0; i < 25; i++) run_cycle(1'b1, 4'b1111, 1'b0, 2'd1);
        // Single-cycle emergency pulse.
        run_cycle(1'b1, 4'b1111, 1'b1, 2'd3);
        for (int i = 0; i < 30; i++) run_cycle(1'b1, 4'b1111, 1'b0, 2'd0);
        async_reset();

        // Randomized phase.
        req_v = 4'b0; dir_v = 2'd0; emg_left = 0; tick_mode = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (n_fail > 40) break;
            if (cyc % 500 == 0) tick_mode = $urandom_range(0, 2);
            case (tick_mode)
                0:       t = 1'b1;
                1:       t = 1'($urandom_range(0, 1));
                default: t = ($urandom_range(0, 3) == 0);
            endcase
            if ($urandom_range(0, 7) == 0) req_v = 4'($urandom_range(0, 15));
            if (emg_left > 0) begin
                emg_left--;
                dir_v = 2'($urandom_range(0, 3));
            end else if ($urandom_range(0, 149) == 0) begin
                emg_left = $urandom_range(1, 40);
                dir_v    = 2'($urandom_range(0, 3));
            end
            run_cycle(t, req_v, emg_left > 0, dir_v);
            if ($urandom_range(0, 699) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
